mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Sequencing stage in front of the pipelined multiplier datapath in the RISCV64 execute stage.
- Accepts one MUL/MULW request per valid/ready handshake from issue, and holds the operands and ALU op stable while the multiplier pipeline runs.
- Counts the multiplier's fixed latency, captures its result into a register, and presents it to writeback with a valid/ready handshake.
- Provides a busy flag for hazard/stall logic and a flush for branch mispredict and trap.

Parameters:
- DATA_BITS, 64, operand/result width; matches the `DATA_BITS define.
- OP_BITS, `ALU_CTRL_BITS, ALU op-code width.
- RD_BITS, 5, destination register index width.
- MUL_LATENCY, 5, cycles from operands presented to the multiplier until its Result is valid; legal range ≥1; identical for MUL and MULW.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- issue_valid  in  1  request present.
- issue_ready  out  1  request accepted this cycle when both valid and ready are high.
- issue_op  in  OP_BITS  ALU op (`ALU_MUL / `ALU_MULW).
- issue_a  in  DATA_BITS  operand A.
- issue_b  in  DATA_BITS  operand B.
- issue_rd  in  RD_BITS  destination register tag.
- flush  in  1  kill in-flight operation.
- mul_a  out  DATA_BITS  operand A to multiplier (registered).
- mul_b  out  DATA_BITS  operand B to multiplier (registered).
- mul_op  out  OP_BITS  ALUOp to multiplier (registered).
- mul_result  in  DATA_BITS  multiplier Result.
- done_valid  out  1  result available.
- done_ready  in  1  writeback accepts.
- done_result  out  DATA_BITS  captured product.
- done_rd  out  RD_BITS  destination tag.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (RST high at an edge):
  - state goes to IDLE.
  - Counter, mul_a, mul_b, mul_op, done_result and done_rd all go to 0.
  - done_valid=0 and busy=0.
  - RST overrides flush and all handshakes. Reset mid-operation discards the operation; no done_valid is produced.
- States: IDLE, BUSY, DONE. Encoding uses 2 bits.
- issue_ready is combinational: (state==IDLE || (state==DONE && done_ready)) && !flush.
- Accept edge t0 (issue_valid && issue_ready):
  - mul_a, mul_b, mul_op and done_rd load from the issue_* inputs.
  - Counter loads MUL_LATENCY-1.
  - state goes to BUSY.
- BUSY:
  - mul_a, mul_b and mul_op are held stable, because the multiplier output mux is combinational on mul_op.
  - Counter decrements once per edge.
  - At the edge where the counter equals 0, done_result captures mul_result and state goes to DONE.
  - The capture edge is t0+MUL_LATENCY, so done_valid rises MUL_LATENCY cycles after acceptance.
- DONE:
  - done_valid=1; done_result and done_rd are held until done_valid && done_ready.
  - On handshake without a new issue, state goes to IDLE.
  - On handshake with a same-cycle new issue, the new request loads as at t0 and state goes to BUSY. This gives back-to-back throughput of one operation per MUL_LATENCY+1 cycles or better.
- done_valid, done_result and done_rd are registered outputs.
- mul_op and operands keep their last values in IDLE and DONE; they are not zeroed.
- Flush:
  - In BUSY or DONE, the next edge goes to IDLE and done_valid drops.
  - The captured result is discarded, even if done_ready is high in the same cycle; no completion is reported.
  - Flush in IDLE has no effect.
  - A flush in the same cycle as issue_valid never accepts, because issue_ready is forced low.
- Ops other than MUL/MULW: accepted and sequenced identically. The result is whatever the multiplier returns (0 for unsupported ops). This block performs no decoding beyond passing the op through.
- MUL_LATENCY=1: the counter loads 0 and the capture happens at the first edge after acceptance.
- Counter width is clog2(MUL_LATENCY)+1 bits; it never wraps.

Decomposition:
- Shared package/defines header holds:
  - state encoding constants (S_IDLE, S_BUSY, S_DONE);
  - RD_BITS;
  - the default MUL_LATENCY, which must equal the multiplier IP latency configuration.
- `DATA_BITS, `ALU_CTRL_BITS, `ALU_MUL and `ALU_MULW come from the existing defines header.
- No sub-module: single FSM plus counter. The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- The bench models the multiplier as a MUL_LATENCY-deep delay line of the 64-bit product (MULW: sign-extended low 32 bits).
- Scenarios:
  1. MUL a=3, b=-2 (0xFFFF_FFFF_FFFF_FFFE), rd=7, done_ready=1 → done_valid exactly 5 cycles after acceptance, done_result=0xFFFF_FFFF_FFFF_FFFA, done_rd=7, busy high for 6 cycles.
  2. MULW a=0x7FFF_FFFF, b=2 → done_result=0xFFFF_FFFF_FFFF_FFFE; mul_op stays `ALU_MULW for all BUSY cycles.
  3. done_ready held low 10 cycles after DONE → done_valid/result/rd stable and issue_ready=0 throughout; releasing done_ready with issue_valid high accepts the next request in that same cycle.
  4. Three back-to-back MULs (2*3, 4*5, 6*7) with issue_valid always high and done_ready always high → results 6, 20, 42 in order, each 5 cycles after its acceptance, no gaps beyond the DONE cycle.
  5. flush asserted on the 3rd BUSY cycle, with issue_valid high in the same cycle → no done_valid, IDLE next edge, issue_ready=0 in the flush cycle, next request completes normally.
  6. RST asserted in DONE with done_valid=1 → next cycle all outputs 0; then MULW 1*1 → result 1 after 5 cycles.

Source files
------------

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared constants and state encoding for the multiplier issue/sequencing stage.
package mul_issue_ctrl_pkg;

    localparam int DATA_BITS_DEF   = 64;
    localparam int ALU_CTRL_BITS   = 5;
    localparam int RD_BITS_DEF     = 5;
    // Must track the latency the multiplier IP is configured for.
    localparam int MUL_LATENCY_DEF = 5;

    localparam logic [ALU_CTRL_BITS-1:0] ALU_MUL  = 5'd10;
    localparam logic [ALU_CTRL_BITS-1:0] ALU_MULW = 5'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_issue_ctrl.sv
// Holds MUL/MULW operands steady for the fixed-latency multiplier, counts its
// latency, captures the product and hands it to writeback over valid/ready.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int OP_BITS     = ALU_CTRL_BITS,
    parameter int RD_BITS     = RD_BITS_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [OP_BITS-1:0]   issue_op,
    input  logic [DATA_BITS-1:0] issue_a,
    input  logic [DATA_BITS-1:0] issue_b,
    input  logic [RD_BITS-1:0]   issue_rd,
    input  logic                 flush,
    output logic [DATA_BITS-1:0] mul_a,
    output logic [DATA_BITS-1:0] mul_b,
    output logic [OP_BITS-1:0]   mul_op,
    input  logic [DATA_BITS-1:0] mul_result,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [DATA_BITS-1:0] done_result,
    output logic [RD_BITS-1:0]   done_rd,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MUL_LATENCY) + 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               capture;

    assign issue_ready = ((state == S_IDLE) || (state == S_DONE && done_ready)) && !flush;
    assign accept      = issue_valid && issue_ready;
    assign capture     = (state == S_BUSY) && (cnt == '0) && !flush;
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = S_BUSY;
            S_BUSY: begin
                if (flush)
                    state_n = S_IDLE;
                else if (cnt == '0)
                    state_n = S_DONE;
            end
            S_DONE: begin
                // Flush wins over a same-cycle writeback handshake: result is dropped.
                if (flush)
                    state_n = S_IDLE;
                else if (done_ready)
                    state_n = accept ? S_BUSY : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_op      <= '0;
            done_valid  <= 1'b0;
            done_result <= '0;
            done_rd     <= '0;
        end else begin
            state      <= state_n;
            done_valid <= (state_n == S_DONE);
            // Operands stay put outside accept: the multiplier's output mux follows mul_op.
            if (accept) begin
                mul_a   <= issue_a;
                mul_b   <= issue_b;
                mul_op  <= issue_op;
                done_rd <= issue_rd;
                cnt     <= CNT_W'(MUL_LATENCY - 1);
            end else if (state == S_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture)
                done_result <= mul_result;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench: multiplier modelled as a delay line, scoreboard of expected products.
module tb_mul_issue_ctrl;
    import mul_issue_ctrl_pkg::*;

    localparam int LAT = 5;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_op;
    logic [63:0] issue_a, issue_b;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [63:0] mul_a, mul_b;
    logic [4:0]  mul_op;
    logic [63:0] mul_result;
    logic        done_valid;
    logic        done_ready;
    logic [63:0] done_result;
    logic [4:0]  done_rd;
    logic        busy;

    mul_issue_ctrl #(.MUL_LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_op(mul_op), .mul_result(mul_result),
        .done_valid(done_valid), .done_ready(done_ready), .done_result(done_result),
        .done_rd(done_rd), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    bit   dv_seen = 1'b0;

    function automatic logic [63:0] prod(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        p = a * b;
        if (op == ALU_MUL)  return p;
        if (op == ALU_MULW) return {{32{p[31]}}, p[31:0]};
        return 64'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Multiplier model: operands registered LAT-1 times, so the product is
    // ready just before the capture edge.
    logic [63:0] pipe [0:LAT-2];
    always @(posedge CLK) begin
        pipe[0] <= prod(mul_op, mul_a, mul_b);
        for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_result = pipe[LAT-2];

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (!done_valid) dv_seen = 1'b0;
            else if (!dv_seen) begin
                dv_seen   = 1'b1;
                first_cyc = cyc;
            end
            if (done_valid && done_ready) begin
                if (sbq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", done_result, e.res);
                    chk("rd", 64'(done_rd), 64'(e.rd));
                    chk("latency", 64'(first_cyc - e.acc), 64'(LAT));
                end
            end
            if (issue_valid && issue_ready)
                sbq.push_back('{prod(issue_op, issue_a, issue_b), issue_rd, cyc + 1});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] rd, input bit keep, output int acc);
        issue_op = op; issue_a = a; issue_b = b; issue_rd = rd; issue_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (issue_ready) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        if (!keep) issue_valid = 1'b0;
        chk("accept_seen", 64'(acc >= 0), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) tick();
        chk("idle_timeout", 64'(busy), 0);
    endtask

    task automatic wait_dv();
        for (int i = 0; i < 60 && !done_valid; i++) tick();
        chk("dv_timeout", 64'(done_valid), 1);
    endtask

    initial begin
        int acc1, acc2, acc3, n, c0;
        bit ok_v, ok_r, ok_d, ok_i, ok_op;

        RST = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_a = '0; issue_b = '0;
        issue_rd = '0; flush = 1'b0; done_ready = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        chk("rst_done_valid", 64'(done_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done_result", done_result, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_issue_ready", 64'(issue_ready), 1);

        // 1: MUL 3 * -2, busy for LAT+1 cycles
        do_issue(ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd7, 1'b0, acc1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            n++;
            tick();
        end
        chk("busy_cycles", 64'(n), 64'(LAT + 1));
        chk("s1_expect", sbq.size(), 0);

        // 2: MULW keeps mul_op stable while busy
        do_issue(ALU_MULW, 64'h7FFF_FFFF, 64'd2, 5'd9, 1'b0, acc1);
        ok_op = 1'b1;
        for (int i = 0; i < 20 && busy && !done_valid; i++) begin
            if (mul_op !== ALU_MULW || mul_a !== 64'h7FFF_FFFF) ok_op = 1'b0;
            tick();
        end
        chk("mulw_op_stable", 64'(ok_op), 1);
        wait_idle();

        // 3: writeback back-pressure, then same-cycle release + issue
        done_ready = 1'b0;
        do_issue(ALU_MUL, 64'd5, 64'd5, 5'd3, 1'b0, acc1);
        wait_dv();
        issue_op = ALU_MUL; issue_a = 64'd11; issue_b = 64'd11; issue_rd = 5'd12; issue_valid = 1'b1;
        ok_v = 1; ok_r = 1; ok_d = 1; ok_i = 1;
        for (int i = 0; i < 10; i++) begin
            if (done_valid !== 1'b1) ok_v = 0;
            if (done_result !== 64'd25) ok_r = 0;
            if (done_rd !== 5'd3) ok_d = 0;
            if (issue_ready !== 1'b0) ok_i = 0;
            tick();
        end
        chk("hold_valid", 64'(ok_v), 1);
        chk("hold_result", 64'(ok_r), 1);
        chk("hold_rd", 64'(ok_d), 1);
        chk("hold_no_ready", 64'(ok_i), 1);
        done_ready = 1'b1;
        c0 = cyc;
        do_issue(ALU_MUL, 64'd11, 64'd11, 5'd12, 1'b0, acc2);
        chk("release_accept_same_cycle", 64'(acc2), 64'(c0 + 1));
        wait_idle();

        // 4: three back-to-back MULs
        do_issue(ALU_MUL, 64'd2, 64'd3, 5'd1, 1'b1, acc1);
        do_issue(ALU_MUL, 64'd4, 64'd5, 5'd2, 1'b1, acc2);
        do_issue(ALU_MUL, 64'd6, 64'd7, 5'd3, 1'b0, acc3);
        chk("b2b_gap1", 64'(acc2 - acc1), 64'(LAT + 1));
        chk("b2b_gap2", 64'(acc3 - acc2), 64'(LAT + 1));
        wait_idle();

        // 5: flush on third BUSY cycle with a pending issue
        do_issue(ALU_MUL, 64'd9, 64'd9, 5'd1, 1'b0, acc1);
        tick(); tick();
        flush = 1'b1;
        issue_op = ALU_MUL; issue_a = 64'd10; issue_b = 64'd10; issue_rd = 5'd2; issue_valid = 1'b1;
        #1;
        chk("flush_issue_ready", 64'(issue_ready), 0);
        void'(sbq.pop_back());
        tick();
        flush = 1'b0;
        chk("flush_idle", 64'(busy), 0);
        chk("flush_no_valid", 64'(done_valid), 0);
        do_issue(ALU_MUL, 64'd10, 64'd10, 5'd2, 1'b0, acc1);
        wait_idle();

        // 6: reset while DONE
        done_ready = 1'b0;
        do_issue(ALU_MUL, 64'd2, 64'd2, 5'd4, 1'b0, acc1);
        wait_dv();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sbq.delete();
        chk("rst2_done_valid", 64'(done_valid), 0);
        chk("rst2_busy", 64'(busy), 0);
        chk("rst2_mul_b", mul_b, 0);
        chk("rst2_mul_op", 64'(mul_op), 0);
        chk("rst2_done_result", done_result, 0);
        chk("rst2_done_rd", 64'(done_rd), 0);
        done_ready = 1'b1;
        do_issue(ALU_MULW, 64'd1, 64'd1, 5'd2, 1'b0, acc1);
        wait_idle();
        tick();

        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
